colour_conversion_controller: RTL and testbench

Sequencing FSM for the YUV-to-RGB colour conversion datapath. On a start pulse it walks the Y, U and V planes one 16-bit word (two pixels) at a time. It drives the datapath's sample-register enables, its pixel/row mux selects and its Temp register, and generates the read and write memory addresses and the write strobe. It sits between the top-level start/done handshake and the datapath plus its single-port synchronous memory.

---
 rtl/colour_conversion_controller.sv | 177 +++++++++++++++++
 tb/tb_colour_conversion_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_conversion_controller.sv
// ============================================================================
// Module  : colour_conversion_controller
// Purpose : Sequencing FSM for the YUV-to-RGB datapath. It reads Y/U/V words
//           and drives the datapath enables, mux selects and memory strobes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module colour_conversion_controller #(
    parameter int PAIRS    = 38400,
    parameter int ADDR_W   = 20,
    parameter int OUT_BASE = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              Yen_even,
    output logic              Yen_odd,
    output logic              Uen_even,
    output logic              Uen_odd,
    output logic              Ven_even,
    output logic              Ven_odd,
    output logic              Smux1,
    output logic [1:0]        Smux2,
    output logic              Temp_en,
    output logic              Cen,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] C_U_BASE   = ADDR_W'(PAIRS);
    localparam logic [ADDR_W-1:0] C_V_BASE   = ADDR_W'(2 * PAIRS);
    localparam logic [ADDR_W-1:0] C_LAST     = ADDR_W'(PAIRS - 1);
    localparam logic [ADDR_W-1:0] C_OUT_BASE = ADDR_W'(OUT_BASE);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RD_Y = 4'd1,
        S_RD_U = 4'd2,
        S_RD_V = 4'd3,
        S_LD_V = 4'd4,
        S_C0   = 4'd5,
        S_C1   = 4'd6,
        S_C2   = 4'd7,
        S_C3   = 4'd8,
        S_C4   = 4'd9,
        S_C5   = 4'd10,
        S_DONE = 4'd11
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pair;
    logic [ADDR_W-1:0] r_wcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pair  <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DONE) begin
                r_pair <= '0;
                r_wcnt <= '0;
            end else begin
                if (wr_en)
                    r_wcnt <= r_wcnt + ADDR_W'(1);
                if (r_state == S_C5 && r_pair != C_LAST)
                    r_pair <= r_pair + ADDR_W'(1);
            end
        end
    end

    // Addresses are forced to zero outside their strobe so idle outputs stay quiet.
    always_comb begin
        w_next   = r_state;
        busy     = (r_state != S_IDLE);
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        Yen_even = 1'b0;
        Yen_odd  = 1'b0;
        Uen_even = 1'b0;
        Uen_odd  = 1'b0;
        Ven_even = 1'b0;
        Ven_odd  = 1'b0;
        Smux1    = 1'b0;
        Smux2    = 2'b11;
        Temp_en  = 1'b0;
        Cen      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;

        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_RD_Y;
            end
            S_RD_Y: begin
                rd_en   = 1'b1;
                rd_addr = r_pair;
                w_next  = S_RD_U;
            end
            S_RD_U: begin
                rd_en    = 1'b1;
                rd_addr  = C_U_BASE + r_pair;
                Yen_even = 1'b1;
                Yen_odd  = 1'b1;
                w_next   = S_RD_V;
            end
            S_RD_V: begin
                rd_en    = 1'b1;
                rd_addr  = C_V_BASE + r_pair;
                Uen_even = 1'b1;
                Uen_odd  = 1'b1;
                w_next   = S_LD_V;
            end
            S_LD_V: begin
                Ven_even = 1'b1;
                Ven_odd  = 1'b1;
                w_next   = S_C0;
            end
            S_C0: begin
                Smux1   = 1'b1;
                Smux2   = 2'b00;
                Temp_en = 1'b1;
                w_next  = S_C1;
            end
            S_C1: begin
                Smux1   = 1'b1;
                Smux2   = 2'b01;
                wr_en   = 1'b1;
                wr_addr = C_OUT_BASE + r_wcnt;
                w_next  = S_C2;
            end
            S_C2: begin
                Smux1   = 1'b1;
                Smux2   = 2'b10;
                Temp_en = 1'b1;
                w_next  = S_C3;
            end
            S_C3: begin
                Smux2   = 2'b00;
                wr_en   = 1'b1;
                wr_addr = C_OUT_BASE + r_wcnt;
                w_next  = S_C4;
            end
            S_C4: begin
                Smux2   = 2'b01;
                Temp_en = 1'b1;
                w_next  = S_C5;
            end
            S_C5: begin
                Smux2   = 2'b10;
                wr_en   = 1'b1;
                wr_addr = C_OUT_BASE + r_wcnt;
                Cen     = 1'b1;
                w_next  = (r_pair == C_LAST) ? S_DONE : S_RD_Y;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_colour_conversion_controller.sv
// ============================================================================
// Module  : tb_colour_conversion_controller
// Purpose : Self-checking bench; per-cycle outputs are compared with a model
//           derived from the frame timing rules (10 cycles per pair).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_colour_conversion_controller;

    localparam int P    = 3;
    localparam int AW   = 20;
    localparam int OB   = 115200;
    localparam int LAST = 10 * P + 1;

    typedef logic [54:0] vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          Yen_even, Yen_odd, Uen_even, Uen_odd, Ven_even, Ven_odd;
    logic          Smux1, Temp_en, Cen;
    logic [1:0]    Smux2;
    vec_t          act;

    int checks   = 0;
    int failures = 0;

    colour_conversion_controller #(
        .PAIRS    (P),
        .ADDR_W   (AW),
        .OUT_BASE (OB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .Yen_even (Yen_even),
        .Yen_odd  (Yen_odd),
        .Uen_even (Uen_even),
        .Uen_odd  (Uen_odd),
        .Ven_even (Ven_even),
        .Ven_odd  (Ven_odd),
        .Smux1    (Smux1),
        .Smux2    (Smux2),
        .Temp_en  (Temp_en),
        .Cen      (Cen),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
    );

    always #5 clk = ~clk;

    assign act = {busy, done, rd_en, rd_addr, Yen_even, Yen_odd, Uen_even, Uen_odd,
                  Ven_even, Ven_odd, Smux1, Smux2, Temp_en, Cen, wr_en, wr_addr};

    // Expected outputs for cycle c of a run (cycle 1 = first read, 0 or past DONE = idle).
    function automatic vec_t exp_vec(input int c);
        logic          b, d, re, we, s1, te, ce;
        logic [AW-1:0] ra, wa;
        logic [5:0]    en;
        logic [1:0]    s2;
        int            k, ph, j;
        b = 0; d = 0; re = 0; we = 0; s1 = 0; te = 0; ce = 0;
        ra = '0; wa = '0; en = '0; s2 = 2'b11;
        if (c == LAST) begin
            b = 1; d = 1;
        end else if (c >= 1 && c < LAST) begin
            b  = 1;
            k  = (c - 1) / 10;
            ph = (c - 1) % 10;
            if (ph == 0) begin re = 1; ra = AW'(k); end
            else if (ph == 1) begin re = 1; ra = AW'(P + k); en = 6'b110000; end
            else if (ph == 2) begin re = 1; ra = AW'(2 * P + k); en = 6'b001100; end
            else if (ph == 3) en = 6'b000011;
            else begin
                j  = ph - 4;
                s1 = (j < 3);
                s2 = 2'(j % 3);
                te = (j % 2 == 0);
                we = (j % 2 == 1);
                if (we) wa = AW'(OB + 3 * k + (j - 1) / 2);
                ce = (j == 5);
            end
        end
        return {b, d, re, ra, en, s1, s2, te, ce, we, wa};
    endfunction

    task automatic test_reset();
        repeat (5) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (act !== exp_vec(0)) begin
                failures++;
                $display("FAIL reset_hold got=%h exp=%h", act, exp_vec(0));
            end
        end
        start = 0;
        rst   = 1;
        @(posedge clk); #1;
        checks++;
        if (act !== exp_vec(0)) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", act, exp_vec(0));
        end
    endtask

    task automatic test_full_frame();
        int       n_wr = 0, n_done = 0;
        logic [AW-1:0] last_wa = '0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= LAST + 2; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = 0;
            checks++;
            if (act !== exp_vec(c)) begin
                failures++;
                $display("FAIL frame cycle=%0d got=%h exp=%h", c, act, exp_vec(c));
            end
            if (wr_en) begin n_wr++; last_wa = wr_addr; end
            if (done) n_done++;
        end
        checks++;
        if (n_wr != 3 * P) begin
            failures++;
            $display("FAIL frame_wr_count got=%0d exp=%0d", n_wr, 3 * P);
        end
        checks++;
        if (n_done != 1) begin
            failures++;
            $display("FAIL frame_done_count got=%0d exp=1", n_done);
        end
        checks++;
        if (last_wa !== AW'(OB + 3 * P - 1)) begin
            failures++;
            $display("FAIL frame_last_wr got=%0d exp=%0d", last_wa, OB + 3 * P - 1);
        end
    endtask

    task automatic test_ignored_starts();
        int n_done = 0;
        #1 start = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= LAST + 3; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = 0;
            checks++;
            if (act !== exp_vec(c)) begin
                failures++;
                $display("FAIL ignored_start cycle=%0d got=%h exp=%h", c, act, exp_vec(c));
            end
            if (done) n_done++;
            if (c <= LAST)
                start = ($urandom_range(0, 2) == 0) || (c == 5) || (c == LAST);
        end
        checks++;
        if (n_done != 1) begin
            failures++;
            $display("FAIL ignored_start_done_count got=%0d exp=1", n_done);
        end
    endtask

    task automatic test_reset_abort();
        int a;
        a = $urandom_range(1, 10 * P);
        #1 start = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= a; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = 0;
            checks++;
            if (act !== exp_vec(c)) begin
                failures++;
                $display("FAIL abort_pre cycle=%0d got=%h exp=%h", c, act, exp_vec(c));
            end
        end
        rst = 0;
        #1;
        checks++;
        if (act !== exp_vec(0)) begin
            failures++;
            $display("FAIL abort_async got=%h exp=%h", act, exp_vec(0));
        end
        repeat (3) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (act !== exp_vec(0)) begin
                failures++;
                $display("FAIL abort_hold got=%h exp=%h", act, exp_vec(0));
            end
        end
        start = 0;
        rst   = 1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= LAST + 1; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = 0;
            checks++;
            if (act !== exp_vec(c)) begin
                failures++;
                $display("FAIL abort_restart cycle=%0d got=%h exp=%h", c, act, exp_vec(c));
            end
        end
    endtask

    task automatic test_back_to_back();
        #1 start = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= LAST + 1; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = 0;
            checks++;
            if (act !== exp_vec(c)) begin
                failures++;
                $display("FAIL b2b_first cycle=%0d got=%h exp=%h", c, act, exp_vec(c));
            end
        end
        start = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= LAST + 2; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = 0;
            checks++;
            if (act !== exp_vec(c)) begin
                failures++;
                $display("FAIL b2b_second cycle=%0d got=%h exp=%h", c, act, exp_vec(c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_ignored_starts();
        test_reset_abort();
        test_back_to_back();
        test_full_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
